// File: rtl/patcnt_pkg.sv
// patcnt_pkg: shared types, default memory map and counter sizing for the pattern-count engine.
package patcnt_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLdPat,
    StScan,
    StWbCtb,
    StWbCto,
    StWbCts,
    StDone
  } state_e;

  localparam int unsigned DefStrBase = 0;
  localparam int unsigned DefPatAddr = 32;
  localparam int unsigned DefResBase = 33;

  // Wide enough to hold the total number of bits in the string without wrapping.
  function automatic int unsigned patcnt_cnt_w(int unsigned num_bytes, int unsigned byte_w);
    return $clog2(num_bytes * byte_w + 1);
  endfunction

endpackage

// File: rtl/patcnt_window_match.sv
// patcnt_window_match: counts masked pattern hits in one {carry, byte} window vector.
// Offsets 0..BYTE_W-PAT_W lie wholly inside the byte; higher offsets straddle the carry.
module patcnt_window_match #(
  parameter int unsigned PAT_W  = 5,
  parameter int unsigned BYTE_W = 8,
  parameter int unsigned KW     = $clog2(BYTE_W + 1)
) (
  input  logic [BYTE_W+PAT_W-2:0] win_i,
  input  logic [PAT_W-1:0]        pat_i,
  input  logic [PAT_W-1:0]        mask_i,
  output logic [KW-1:0]           in_cnt_o,
  output logic [KW-1:0]           x_cnt_o
);

  logic [PAT_W-1:0] slice;

  // Slide over every window start and split hits into in-byte and crossing counts.
  always_comb begin
    in_cnt_o = '0;
    x_cnt_o  = '0;
    slice    = '0;
    for (int unsigned o = 0; o < BYTE_W; o++) begin
      slice = PAT_W'(win_i >> o);
      if (((slice ^ pat_i) & mask_i) == '0) begin
        if (o <= BYTE_W - PAT_W) in_cnt_o = in_cnt_o + KW'(1);
        else                     x_cnt_o  = x_cnt_o + KW'(1);
      end
    end
  end

endmodule

// File: rtl/pattern_count_engine.sv
// pattern_count_engine: reads a pattern and a bit string from data memory, counts in-byte
// hits, bytes with a hit and stream-wide hits, then writes the three counts back.
// Define PATCNT_MASK_EN to also load a care-mask word from PAT_ADDR+3.
module pattern_count_engine
  import patcnt_pkg::*;
#(
  parameter int unsigned PAT_W     = 5,
  parameter int unsigned BYTE_W    = 8,
  parameter int unsigned NUM_BYTES = 32,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned STR_BASE  = DefStrBase,
  parameter int unsigned PAT_ADDR  = DefPatAddr,
  parameter int unsigned RES_BASE  = DefResBase
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              req_i,
  output logic              done_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wr_en_o,
  output logic [BYTE_W-1:0] mem_wr_data_o,
  input  logic [BYTE_W-1:0] mem_rd_data_i
);

  localparam int unsigned CntW = patcnt_cnt_w(NUM_BYTES, BYTE_W);
  localparam int unsigned KW   = $clog2(BYTE_W + 1);
  localparam int unsigned IdxW = $clog2(NUM_BYTES + 1);
  localparam int unsigned CW   = (PAT_W > 1) ? PAT_W - 1 : 1;
  localparam int unsigned WinW = BYTE_W + PAT_W - 1;
`ifdef PATCNT_MASK_EN
  localparam logic [1:0] LdLast = 2'd2;
`else
  localparam logic [1:0] LdLast = 2'd1;
`endif

  state_e            state_q, state_d;
  logic [1:0]        ld_q, ld_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [PAT_W-1:0]  pat_q, pat_d, mask;
  logic [CW-1:0]     carry_q, carry_d;
  logic [CntW-1:0]   ctb_q, ctb_d, cto_q, cto_d, cts_q, cts_d;
  logic [WinW-1:0]   win;
  logic [KW-1:0]     in_cnt, x_cnt;

`ifdef PATCNT_MASK_EN
  logic [PAT_W-1:0]  mask_q, mask_d;

  // Care-mask register, loaded alongside the pattern.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) mask_q <= '0;
    else           mask_q <= mask_d;
  end
  assign mask = mask_q;
`else
  assign mask = '1;
`endif

  // The carry holds the tail of the previous byte so crossing windows can be formed.
  if (PAT_W > 1) begin : g_carry
    assign win = {carry_q, mem_rd_data_i};
  end else begin : g_nocarry
    assign win = mem_rd_data_i;
  end

  patcnt_window_match #(
    .PAT_W (PAT_W),
    .BYTE_W(BYTE_W),
    .KW    (KW)
  ) u_match (
    .win_i   (win),
    .pat_i   (pat_q),
    .mask_i  (mask),
    .in_cnt_o(in_cnt),
    .x_cnt_o (x_cnt)
  );

  // State, pattern, carry and counter registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      ld_q    <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
      carry_q <= '0;
      ctb_q   <= '0;
      cto_q   <= '0;
      cts_q   <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      carry_q <= carry_d;
      ctb_q   <= ctb_d;
      cto_q   <= cto_d;
      cts_q   <= cts_d;
    end
  end

  // Next-state, datapath updates and memory-port outputs.
  always_comb begin
    state_d       = state_q;
    ld_d          = ld_q;
    idx_d         = idx_q;
    pat_d         = pat_q;
    carry_d       = carry_q;
    ctb_d         = ctb_q;
    cto_d         = cto_q;
    cts_d         = cts_q;
`ifdef PATCNT_MASK_EN
    mask_d        = mask_q;
`endif
    mem_addr_o    = '0;
    mem_wr_en_o   = 1'b0;
    mem_wr_data_o = '0;
    busy_o        = 1'b1;
    done_o        = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        busy_o = 1'b0;
        done_o = (state_q == StDone);
        if (req_i) begin
          state_d = StLdPat;
          ld_d    = '0;
        end
      end
      StLdPat: begin
        ld_d = ld_q + 2'd1;
        if (ld_q == 2'd0) mem_addr_o = ADDR_W'(PAT_ADDR);
        if (ld_q == 2'd1) pat_d = mem_rd_data_i[BYTE_W-1 -: PAT_W];
`ifdef PATCNT_MASK_EN
        if (ld_q == 2'd1) mem_addr_o = ADDR_W'(PAT_ADDR + 3);
        if (ld_q == 2'd2) mask_d = mem_rd_data_i[BYTE_W-1 -: PAT_W];
`endif
        if (ld_q == LdLast) begin
          mem_addr_o = ADDR_W'(STR_BASE);
          ctb_d      = '0;
          cto_d      = '0;
          cts_d      = '0;
          carry_d    = '0;
          idx_d      = IdxW'(1);
          state_d    = StScan;
        end
      end
      StScan: begin
        // idx_q addresses the next byte; rd_data carries byte idx_q-1.
        ctb_d   = ctb_q + CntW'(in_cnt);
        cto_d   = cto_q + CntW'(in_cnt != '0);
        cts_d   = cts_q + CntW'(in_cnt) + ((idx_q > IdxW'(1)) ? CntW'(x_cnt) : '0);
        carry_d = CW'(mem_rd_data_i);
        if (idx_q == IdxW'(NUM_BYTES)) begin
          state_d = StWbCtb;
        end else begin
          mem_addr_o = ADDR_W'(STR_BASE) + ADDR_W'(idx_q);
          idx_d      = idx_q + IdxW'(1);
        end
      end
      StWbCtb: begin
        mem_addr_o    = ADDR_W'(RES_BASE);
        mem_wr_en_o   = 1'b1;
        mem_wr_data_o = BYTE_W'(ctb_q);
        state_d       = StWbCto;
      end
      StWbCto: begin
        mem_addr_o    = ADDR_W'(RES_BASE + 1);
        mem_wr_en_o   = 1'b1;
        mem_wr_data_o = BYTE_W'(cto_q);
        state_d       = StWbCts;
      end
      StWbCts: begin
        mem_addr_o    = ADDR_W'(RES_BASE + 2);
        mem_wr_en_o   = 1'b1;
        mem_wr_data_o = BYTE_W'(cts_q);
        state_d       = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_pattern_count_engine.sv
// tb_pattern_count_engine: random and directed runs checked against a bit-stream model.
// Honours PATCNT_MASK_EN to exercise the care-mask build.
module tb_pattern_count_engine;

  localparam int PatW     = 5;
  localparam int ByteW    = 8;
  localparam int NumBytes = 32;
  localparam int AddrW    = 8;
  localparam int StrBase  = 0;
  localparam int PatAddr  = 32;
  localparam int ResBase  = 33;
  localparam int NumBits  = NumBytes * ByteW;
`ifdef PATCNT_MASK_EN
  localparam int Lat = NumBytes + 7;
`else
  localparam int Lat = NumBytes + 6;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req;
  logic             done, busy, wr_en;
  logic [AddrW-1:0] addr;
  logic [ByteW-1:0] wr_data, rd_data;

  logic [ByteW-1:0] img [256];
  logic [ByteW-1:0] res [256];
  int unsigned      wr_cnt = 0;
  int               n_tests = 0;
  int               n_fail = 0;

  always #5 clk = ~clk;

  pattern_count_engine #(
    .PAT_W    (PatW),
    .BYTE_W   (ByteW),
    .NUM_BYTES(NumBytes),
    .ADDR_W   (AddrW),
    .STR_BASE (StrBase),
    .PAT_ADDR (PatAddr),
    .RES_BASE (ResBase)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .req_i        (req),
    .done_o       (done),
    .busy_o       (busy),
    .mem_addr_o   (addr),
    .mem_wr_en_o  (wr_en),
    .mem_wr_data_o(wr_data),
    .mem_rd_data_i(rd_data)
  );

  // Synchronous data memory: reads from the stimulus image, writes logged separately.
  always @(posedge clk) begin
    rd_data <= img[addr];
    if (wr_en) begin
      res[addr] <= wr_data;
      wr_cnt    <= wr_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: treat the string as one MSB-first bit stream and test every window start.
  function automatic void model(input logic [PatW-1:0] pat, input logic [PatW-1:0] mask,
                                output int ctb, output int cto, output int cts);
    bit s [NumBits];
    bit hit [NumBytes];
    bit m;
    ctb = 0;
    cto = 0;
    cts = 0;
    for (int p = 0; p < NumBits; p++) s[p] = img[StrBase + p / ByteW][ByteW - 1 - p % ByteW];
    for (int b = 0; b < NumBytes; b++) hit[b] = 1'b0;
    for (int p = 0; p <= NumBits - PatW; p++) begin
      m = 1'b1;
      for (int k = 0; k < PatW; k++)
        if (mask[PatW-1-k] && (s[p+k] != pat[PatW-1-k])) m = 1'b0;
      if (m) begin
        cts++;
        if ((p % ByteW) <= ByteW - PatW) begin
          ctb++;
          hit[p / ByteW] = 1'b1;
        end
      end
    end
    for (int b = 0; b < NumBytes; b++) cto += int'(hit[b]);
  endfunction

  task automatic fill_const(input logic [ByteW-1:0] v);
    for (int i = 0; i < NumBytes; i++) img[StrBase + i] = v;
  endtask

  task automatic run_case(input string tag, input logic [PatW-1:0] pat,
                          input logic [PatW-1:0] mask, input bit extra_req);
    logic [PatW-1:0] eff;
    int ctb, cto, cts, cyc;
    int unsigned w0;
    img[PatAddr] = {pat, 3'($urandom)};
`ifdef PATCNT_MASK_EN
    eff = mask;
    img[PatAddr + 3] = {mask, 3'($urandom)};
`else
    eff = '1;
`endif
    model(pat, eff, ctb, cto, cts);
    w0 = wr_cnt;
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    cyc = 1;
    check_eq($sformatf("%s.busy_start", tag), 32'(busy), 32'd1);
    check_eq($sformatf("%s.done_drop", tag), 32'(done), 32'd0);
    while (!done && cyc < Lat + 20) begin
      req = (extra_req && cyc == 5);
      @(negedge clk);
      cyc++;
    end
    req = 1'b0;
    check_eq($sformatf("%s.latency", tag), cyc, Lat);
    check_eq($sformatf("%s.busy_end", tag), 32'(busy), 32'd0);
    check_eq($sformatf("%s.nwrites", tag), wr_cnt - w0, 32'd3);
    check_eq($sformatf("%s.ctb", tag), 32'(res[ResBase]), ctb & 8'hFF);
    check_eq($sformatf("%s.cto", tag), 32'(res[ResBase + 1]), cto & 8'hFF);
    check_eq($sformatf("%s.cts", tag), 32'(res[ResBase + 2]), cts & 8'hFF);
    repeat (3) @(negedge clk);
    check_eq($sformatf("%s.done_hold", tag), 32'(done), 32'd1);
  endtask

  initial begin
    logic [PatW-1:0] p, mk;
    int unsigned w0;
    reset_n = 1'b0;
    req     = 1'b0;
    for (int i = 0; i < 256; i++) img[i] = '0;
    repeat (2) @(negedge clk);
    check_eq("rst.done", 32'(done), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.addr", 32'(addr), 32'd0);
    check_eq("rst.wr_en", 32'(wr_en), 32'd0);
    check_eq("rst.wr_data", 32'(wr_data), 32'd0);
    reset_n = 1'b1;

    fill_const(8'h00);
    run_case("zeros", 5'b00000, 5'b11111, 1'b0);
    fill_const(8'h55);
    run_case("alt55", 5'b10101, 5'b11111, 1'b0);
    fill_const(8'h00);
    img[StrBase] = 8'h1F;
    run_case("ones_b0", 5'b11111, 5'b11111, 1'b0);
    img[StrBase]     = 8'h03;
    img[StrBase + 1] = 8'hE0;
    run_case("cross", 5'b11111, 5'b11111, 1'b0);

    // Abort mid-scan: no result writes, outputs return to reset values immediately.
    for (int i = 0; i < NumBytes; i++) img[StrBase + i] = 8'($urandom);
    w0 = wr_cnt;
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("abort.busy_scan", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("abort.busy", 32'(busy), 32'd0);
    check_eq("abort.done", 32'(done), 32'd0);
    check_eq("abort.addr", 32'(addr), 32'd0);
    check_eq("abort.wr_en", 32'(wr_en), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("abort.nwrites", wr_cnt - w0, 32'd0);
    check_eq("abort.idle", 32'(busy | done), 32'd0);
    fill_const(8'h00);
    run_case("rerun", 5'b00000, 5'b11111, 1'b1);

`ifdef PATCNT_MASK_EN
    run_case("mask_f8", 5'b11111, 5'b11111, 1'b0);
    run_case("mask_e0", 5'b11111, 5'b11100, 1'b0);
    run_case("mask_00", 5'b11111, 5'b00000, 1'b0);
`endif

    for (int t = 0; t < 16; t++) begin
      p  = PatW'($urandom);
      mk = ($urandom_range(0, 2) == 0) ? PatW'($urandom) : '1;
      for (int i = 0; i < NumBytes; i++) begin
        case ($urandom_range(0, 3))
          0:       img[StrBase + i] = 8'h00;
          1:       img[StrBase + i] = 8'hFF;
          2:       img[StrBase + i] = {p, 3'($urandom)};
          default: img[StrBase + i] = 8'($urandom);
        endcase
      end
      run_case($sformatf("rand%0d", t), p, mk, t[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
